// File: rtl/pixel_stream_loader_if.sv
// Pixel stream loader bus: the sensor-side valid/ready pixel stream and
// the image-memory write port, grouped so the loader and its source/sink
// connect with a single port each.
interface pixel_stream_loader_if;
   // sensor stream
   logic       frameStart;
   logic       pixValid;
   logic       pixData;
   logic       pixReady;
   // image memory write port
   logic       writeMem;
   logic [7:0] xAddressIn;
   logic [7:0] yAddressIn;
   logic       dataIn;

   // pixel source / memory observer side
   modport master (
      output frameStart, pixValid, pixData,
      input  pixReady, writeMem, xAddressIn, yAddressIn, dataIn
   );

   // loader side
   modport slave (
      input  frameStart, pixValid, pixData,
      output pixReady, writeMem, xAddressIn, yAddressIn, dataIn
   );
endinterface

// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader: takes a raster-ordered 1-bit pixel stream, writes
// each pixel into the image memory, pulses start after the last pixel of
// a frame and then back-pressures the source for HOLDOFF_CYCLES while the
// median filter reads the memory.
// Optional feature: define LOADER_TIMEOUT_EN to abandon a frame (flagging
// frameError) when no pixel arrives for TIMEOUT_CYCLES cycles mid-frame.
module pixel_stream_loader #(
   parameter int IMG_WIDTH      = 160,
   parameter int IMG_HEIGHT     = 120,
   parameter int HOLDOFF_CYCLES = 40000
`ifdef LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                        clk,
   input  logic                        reset,
   pixel_stream_loader_if.slave        bus,
   output logic                        start,
   output logic                        busy,
   output logic                        frameError,
   output logic [15:0]                 frameCount
);

   localparam logic [7:0]  X_LAST  = 8'(IMG_WIDTH - 1);
   localparam logic [7:0]  Y_LAST  = 8'(IMG_HEIGHT - 1);
   localparam logic [15:0] HOLD_LD = 16'(HOLDOFF_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_x;          // raster position of the next expected beat
   logic [7:0]  r_y;
   logic [15:0] r_hold;
   logic        r_pix_ready;
   logic        r_write;
   logic [7:0]  r_x_addr;
   logic [7:0]  r_y_addr;
   logic        r_data;
   logic        r_start;
   logic        r_err;
   logic [15:0] r_count;

   logic        w_accept;
   logic [7:0]  w_pos_x;
   logic [7:0]  w_pos_y;
   logic        w_last_col;
   logic        w_last_pix;
   logic [7:0]  w_x_adv;
   logic [7:0]  w_y_adv;
   logic        w_write;
   logic        w_err_set;
   logic        w_err_clr;
   logic        w_start_next;

`ifdef LOADER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmo;
`endif

   // A frameStart beat always lands at (0,0), whether it opens a frame or
   // restarts one; otherwise the beat takes the next raster position.
   assign w_accept   = bus.pixValid & r_pix_ready;
   assign w_pos_x    = bus.frameStart ? 8'd0 : r_x;
   assign w_pos_y    = bus.frameStart ? 8'd0 : r_y;
   assign w_last_col = (w_pos_x == X_LAST);
   assign w_last_pix = w_last_col && (w_pos_y == Y_LAST);
   assign w_x_adv    = w_last_col ? 8'd0 : w_pos_x + 8'd1;
   assign w_y_adv    = w_last_col ? w_pos_y + 8'd1 : w_pos_y;

   // Next-state and control decode for the loader FSM.
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_err_set    = 1'b0;
      w_err_clr    = 1'b0;
      w_start_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && bus.frameStart) begin
               w_write      = 1'b1;
               w_err_clr    = 1'b1;
               w_state_next = w_last_pix ? S_KICK : S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_accept) begin
               w_write = 1'b1;
               if (bus.frameStart) begin
                  w_err_set = 1'b1;
               end
               if (w_last_pix) begin
                  w_state_next = S_KICK;
               end
            end
`ifdef LOADER_TIMEOUT_EN
            else if (r_tmo == TMO_LAST) begin
               w_err_set    = 1'b1;
               w_state_next = S_IDLE;
            end
`endif
         end
         S_KICK: begin
            w_start_next = 1'b1;
            w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (r_hold == 16'd0) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register; pixReady is registered from the next state so it is
   // low while reset is asserted and tracks IDLE/LOAD afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_pix_ready <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pix_ready <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD);
      end
   end

   // Raster position of the next beat, advanced on every written beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x <= 8'd0;
         r_y <= 8'd0;
      end else if (w_write) begin
         r_x <= w_x_adv;
         r_y <= w_y_adv;
      end
   end

   // Registered memory write port; address/data hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write  <= 1'b0;
         r_x_addr <= 8'd0;
         r_y_addr <= 8'd0;
         r_data   <= 1'b0;
      end else begin
         r_write <= w_write;
         if (w_write) begin
            r_x_addr <= w_pos_x;
            r_y_addr <= w_pos_y;
            r_data   <= bus.pixData;
         end
      end
   end

   // Start pulse, completed-frame counter and sticky frame error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start <= 1'b0;
         r_count <= 16'd0;
         r_err   <= 1'b0;
      end else begin
         r_start <= w_start_next;
         if (w_start_next) begin
            r_count <= r_count + 16'd1;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (w_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   // Holdoff down-counter, loaded while KICK so it counts from the start cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold <= 16'd0;
      end else if (r_state == S_KICK) begin
         r_hold <= HOLD_LD;
      end else if ((r_state == S_HOLD) && (r_hold != 16'd0)) begin
         r_hold <= r_hold - 16'd1;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   // Inter-pixel idle counter, only running while a frame is being loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmo <= 16'd0;
      end else if ((r_state == S_LOAD) && !w_accept) begin
         r_tmo <= r_tmo + 16'd1;
      end else begin
         r_tmo <= 16'd0;
      end
   end
`endif

   assign bus.pixReady   = r_pix_ready;
   assign bus.writeMem   = r_write;
   assign bus.xAddressIn = r_x_addr;
   assign bus.yAddressIn = r_y_addr;
   assign bus.dataIn     = r_data;
   assign start          = r_start;
   assign busy           = (r_state != S_IDLE);
   assign frameError     = r_err;
   assign frameCount     = r_count;

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Testbench for pixel_stream_loader: directed frames checked every cycle
// against a cycle-scheduled model of the loader's observable behaviour,
// plus literal expectations per scenario.
module tb_pixel_stream_loader;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int HOLD = 5;
   localparam int TMO  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start;
   logic        busy;
   logic        frame_error;
   logic [15:0] frame_count;

   pixel_stream_loader_if bus();

   pixel_stream_loader #(
      .IMG_WIDTH      (W),
      .IMG_HEIGHT     (H),
      .HOLDOFF_CYCLES (HOLD)
`ifdef LOADER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TMO)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .start      (start),
      .busy       (busy),
      .frameError (frame_error),
      .frameCount (frame_count)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // model state
   int cyc = 0;
   bit in_frame = 0;
   int idx = 0;
   bit m_err = 0, m_err_nx = 0;
   int m_count = 0;
   bit wr_pend = 0;
   int pend_x = 0, pend_y = 0, pend_d = 0;
   bit exp_write = 0;
   int exp_x = 0, exp_y = 0, exp_d = 0;
   int start_at = -10;
   int ready_from = 2;
   int busy_until = 0;
   int last_acc = 0;

   // observation logs for literal checks
   int log_x[$];
   int log_y[$];
   int log_d[$];
   int n_start = 0;
   int start_cyc = 0;
   int last_wr_cyc = 0;
   bit tracking = 0;
   int low_run = 0;
   int last_run = 0;
   bit busy_seen = 0;

   // Per-cycle compare against the model, then advance the model by this cycle's accept.
   always @(negedge clk) begin
      if (!reset) begin
         cyc = 0; in_frame = 0; idx = 0; m_err = 0; m_err_nx = 0; m_count = 0;
         wr_pend = 0; exp_write = 0; exp_x = 0; exp_y = 0; exp_d = 0;
         start_at = -10; ready_from = 2; busy_until = 0; last_acc = 0;
         check("rst_writeMem", 32'(bus.writeMem), 0);
         check("rst_pixReady", 32'(bus.pixReady), 0);
         check("rst_start", 32'(start), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_frameError", 32'(frame_error), 0);
         check("rst_frameCount", 32'(frame_count), 0);
         check("rst_xy", {16'(bus.xAddressIn), 16'(bus.yAddressIn)}, 0);
         check("rst_dataIn", 32'(bus.dataIn), 0);
      end else begin
         cyc++;
         exp_write = wr_pend;
         if (wr_pend) begin
            exp_x = pend_x; exp_y = pend_y; exp_d = pend_d;
         end
         wr_pend = 0;
         m_err = m_err_nx;
`ifdef LOADER_TIMEOUT_EN
         if (in_frame && cyc == last_acc + TMO + 1) begin
            in_frame = 0; m_err = 1; m_err_nx = 1;
         end
`endif
         if (cyc == start_at) m_count = (m_count + 1) % 65536;
         check("writeMem", 32'(bus.writeMem), 32'(exp_write));
         check("xAddressIn", 32'(bus.xAddressIn), 32'(exp_x));
         check("yAddressIn", 32'(bus.yAddressIn), 32'(exp_y));
         check("dataIn", 32'(bus.dataIn), 32'(exp_d));
         check("start", 32'(start), 32'(cyc == start_at));
         check("pixReady", 32'(bus.pixReady), 32'(cyc >= ready_from));
         check("busy", 32'(busy), 32'(in_frame || cyc < busy_until));
         check("frameError", 32'(frame_error), 32'(m_err));
         check("frameCount", 32'(frame_count), 32'(m_count));

         if (bus.writeMem) begin
            log_x.push_back(int'(bus.xAddressIn));
            log_y.push_back(int'(bus.yAddressIn));
            log_d.push_back(int'(bus.dataIn));
            last_wr_cyc = cyc;
            $display("write x=%0d y=%0d d=%0d cycle=%0d", bus.xAddressIn, bus.yAddressIn, bus.dataIn, cyc);
         end
         if (start) begin
            n_start++; start_cyc = cyc; tracking = 1; low_run = 0;
            $display("start frameCount=%0d cycle=%0d", frame_count, cyc);
         end
         if (tracking) begin
            if (!bus.pixReady) low_run++;
            else begin tracking = 0; last_run = low_run; end
         end
         if (busy) busy_seen = 1;

         if (bus.pixValid && cyc >= ready_from) begin
            last_acc = cyc;
            if (bus.frameStart) begin
               m_err_nx = in_frame;
               in_frame = 1;
               idx = 0;
            end
            if (in_frame) begin
               pend_x = idx % W; pend_y = idx / W; pend_d = int'(bus.pixData);
               wr_pend = 1;
               idx++;
               if (idx == W * H) begin
                  in_frame = 0;
                  start_at = cyc + 2;
                  ready_from = cyc + 3 + HOLD;
                  busy_until = ready_from;
               end
            end
         end
      end
   end

   task automatic clear_logs();
      log_x.delete(); log_y.delete(); log_d.delete();
      n_start = 0; busy_seen = 0; last_run = 0;
   endtask

   // One beat held valid until accepted (bounded wait).
   task automatic beat(input logic fs, input logic d);
      int  w;
      logic got;
      bus.pixValid = 1'b1; bus.frameStart = fs; bus.pixData = d;
      w = 0;
      while (1) begin
         @(negedge clk);
         got = bus.pixReady;
         @(posedge clk);
         #1;
         if (got) break;
         w++;
         if (w > 100) begin
            n_vec++; n_miss++;
            $display("FAIL beat_accept: not accepted after %0d cycles, expected acceptance", w);
            break;
         end
      end
      bus.pixValid = 1'b0; bus.frameStart = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.pixValid = 1'b0; bus.frameStart = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame(input bit gapped);
      for (int i = 0; i < W * H; i++) begin
         beat(i == 0, ((i % 2) == 0));
         if (gapped) idle(1);
      end
   endtask

   task automatic check_frame_log(input string tag);
      logic [11:0] bits;
      bits = '0;
      check({tag, "_nwrites"}, 32'(log_d.size()), 12);
      if (log_d.size() == 12) begin
         for (int i = 0; i < 12; i++) bits = {bits[10:0], log_d[i][0]};
         check({tag, "_data"}, 32'(bits), 32'(12'b101010101010));
         check({tag, "_x4y4"}, {16'(log_x[4]), 16'(log_y[4])}, {16'd0, 16'd1});
         check({tag, "_x3y3"}, {16'(log_x[3]), 16'(log_y[3])}, {16'd3, 16'd0});
         check({tag, "_x11y11"}, {16'(log_x[11]), 16'(log_y[11])}, {16'd3, 16'd2});
      end
      check({tag, "_nstart"}, 32'(n_start), 1);
      check({tag, "_start_after_last_write"}, 32'(start_cyc - last_wr_cyc), 1);
      check({tag, "_ready_low_run"}, 32'(last_run), 6);
   endtask

   initial begin
      bus.pixValid = 1'b0; bus.frameStart = 1'b0; bus.pixData = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      // full frame, back-to-back
      clear_logs();
      frame(0);
      idle(12);
      check_frame_log("full");
      check("full_frameCount", 32'(frame_count), 1);

      // gapped stream
      clear_logs();
      frame(1);
      idle(12);
      check_frame_log("gapped");
      check("gapped_frameCount", 32'(frame_count), 2);

      // restart mid-frame on beat 6
      clear_logs();
      for (int i = 0; i < 6; i++) beat(i == 0, 1'b1);
      beat(1'b1, 1'b0);
      @(negedge clk);
      check("restart_error_set", 32'(frame_error), 1);
      check("restart_write_xy", {16'(bus.xAddressIn), 16'(bus.yAddressIn)}, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) beat(1'b0, 1'b1);
      idle(2);
      check("restart_no_early_start", 32'(n_start), 0);
      beat(1'b0, 1'b1);
      idle(12);
      check("restart_nstart", 32'(n_start), 1);
      check("restart_error_sticky", 32'(frame_error), 1);
      clear_logs();
      frame(0);
      idle(12);
      check("next_frame_error_cleared", 32'(frame_error), 0);
      check("next_frame_nstart", 32'(n_start), 1);

      // idle garbage
      clear_logs();
      for (int i = 0; i < 3; i++) beat(1'b0, 1'b1);
      idle(3);
      check("garbage_nwrites", 32'(log_d.size()), 0);
      check("garbage_busy_seen", 32'(busy_seen), 0);
      check("garbage_ready", 32'(bus.pixReady), 1);

      // reset mid-frame
      clear_logs();
      for (int i = 0; i < 5; i++) beat(i == 0, 1'b1);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(2);
      check("reset_nstart", 32'(n_start), 0);
      clear_logs();
      frame(0);
      idle(12);
      check_frame_log("after_reset");
      check("after_reset_frameCount", 32'(frame_count), 1);

`ifdef LOADER_TIMEOUT_EN
      // stall mid-frame until the timeout abandons it
      clear_logs();
      for (int i = 0; i < 4; i++) beat(i == 0, 1'b1);
      idle(12);
      check("timeout_error", 32'(frame_error), 1);
      check("timeout_busy", 32'(busy), 0);
      check("timeout_nstart", 32'(n_start), 0);
      check("timeout_frameCount", 32'(frame_count), 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
